router_port_rx: RTL and testbench

ROUTER_PORT_RX -- requirements
Module: router_port_rx

---
 rtl/router_port_rx.sv | 166 ++++++++++++++++
 tb/tb_router_port_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/router_port_rx.sv
// Serial router input port receiver: deserialises address and payload bits
// into bytes and buffers them with packet framing flags in a small FIFO.
module router_port_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       din,
    input  logic       frame_n,
    input  logic       valid_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_addr,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    output logic       err_frame,
    output logic       overflow,
    output logic       busy_n
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, PAD, DATA} state_t;

    state_t      state, state_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [3:0]  addr_reg, addr_next;
    logic [7:0]  byte_reg, byte_next;
    logic        first, first_next;
    logic        take_bit;
    logic        push, push_eop, err_next;

    logic [13:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, pop, do_write;
    logic [13:0]      push_entry;

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        addr_next    = addr_reg;
        byte_next    = byte_reg;
        first_next   = first;
        take_bit     = 1'b0;
        push         = 1'b0;
        push_eop     = 1'b0;
        err_next     = 1'b0;

        case (state)
            IDLE: begin
                if (!frame_n) begin
                    addr_next    = {3'b000, din};
                    bit_cnt_next = 3'd1;
                    first_next   = 1'b1;
                    state_next   = ADDR;
                end
            end
            ADDR: begin
                if (frame_n) begin
                    err_next     = 1'b1;
                    bit_cnt_next = 3'd0;
                    state_next   = IDLE;
                end else begin
                    addr_next[bit_cnt[1:0]] = din;
                    if (bit_cnt == 3'd3) begin
                        bit_cnt_next = 3'd0;
                        state_next   = PAD;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            PAD: begin
                if (frame_n) begin
                    err_next     = 1'b1;
                    bit_cnt_next = 3'd0;
                    state_next   = IDLE;
                end else if (!valid_n) begin
                    take_bit = 1'b1;
                end
            end
            DATA: begin
                if (!valid_n) take_bit = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        // A payload bit either completes a byte (push) or, if it is the last
        // bit of the frame on a partial byte, aborts the packet tail.
        if (take_bit) begin
            byte_next[bit_cnt] = din;
            state_next         = DATA;
            if (bit_cnt == 3'd7) begin
                push         = 1'b1;
                push_eop     = frame_n;
                first_next   = 1'b0;
                bit_cnt_next = 3'd0;
                if (frame_n) state_next = IDLE;
            end else if (frame_n) begin
                err_next     = 1'b1;
                bit_cnt_next = 3'd0;
                state_next   = IDLE;
            end else begin
                bit_cnt_next = bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            addr_reg  <= 4'd0;
            byte_reg  <= 8'd0;
            first     <= 1'b0;
            err_frame <= 1'b0;
            busy_n    <= 1'b1;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            addr_reg  <= addr_next;
            byte_reg  <= byte_next;
            first     <= first_next;
            err_frame <= err_next;
            busy_n    <= (state_next == IDLE);
        end
    end

    // A push into a full FIFO still lands when the head is popped the same edge.
    assign full       = (count == CNT_FULL);
    assign pop        = out_valid & out_ready;
    assign do_write   = push & (~full | pop);
    assign push_entry = {addr_reg, byte_next, first, push_eop};

    always_ff @(posedge clock) begin
        if (do_write) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_write, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push & full & ~pop) overflow <= 1'b1;
        end
    end

    assign out_valid = (count != '0);
    assign {out_addr, out_data, out_sop, out_eop} = out_valid ? mem[rd_ptr] : 14'd0;

endmodule

// File: tb/tb_router_port_rx.sv
// Randomised bench for router_port_rx: packet-level stimulus with a queue-based
// scoreboard of expected FIFO contents, overflow and framing-error pulses.
module tb_router_port_rx;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       din, frame_n, valid_n;
    logic       out_valid, out_ready;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       out_sop, out_eop, err_frame, overflow, busy_n;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;          // 0: hold low, 1: hold high, 2: random
    logic [13:0] model_q[$];     // {addr, data, sop, eop}
    logic        model_ovf = 1'b0;
    logic [7:0]  pkt [8];

    router_port_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .din(din), .frame_n(frame_n),
        .valid_n(valid_n), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .err_frame(err_frame), .overflow(overflow),
        .busy_n(busy_n)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, update the model at the edge, check at negedge.
    task automatic cycle(input logic d, input logic f, input logic v, input logic do_push,
                         input logic [13:0] entry, input logic exp_err, input logic exp_busy);
        din     = d;
        frame_n = f;
        valid_n = v;
        out_ready = (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
        @(posedge clock);
        if (out_ready && model_q.size() != 0) void'(model_q.pop_front());
        if (do_push) begin
            if (model_q.size() < DEPTH) model_q.push_back(entry);
            else model_ovf = 1'b1;
        end
        @(negedge clock);
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0)
            check("head", 32'({out_addr, out_data, out_sop, out_eop}), 32'(model_q[0]));
        check("err_frame", 32'(err_frame), 32'(exp_err));
        check("overflow", 32'(overflow), 32'(model_ovf));
        check("busy_n", 32'(busy_n), 32'(exp_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'($urandom), 1'b1, 1'($urandom), 1'b0, 14'd0, 1'b0, 1'b1);
    endtask

    // Sends addr, pad, then n bytes from pkt[]; the final byte carries last_bits bits.
    task automatic send_packet(input logic [3:0] a, input int n, input int pad,
                               input bit gaps, input int last_bits);
        int total = (n - 1) * 8 + last_bits;
        for (int i = 0; i < 4; i++) cycle(a[i], 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 1'b0);
        for (int i = 0; i < pad; i++) cycle(1'($urandom), 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 1'b0);
        for (int k = 0; k < total; k++) begin
            int ng = 0;
            logic [7:0] b;
            logic last;
            if (gaps && k > 0) ng = (k == 3) ? 2 : int'($urandom % 3);
            for (int g = 0; g < ng; g++)
                cycle(1'($urandom), 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 1'b0);
            b = pkt[k / 8];
            last = (k == total - 1);
            cycle(b[k % 8], last, 1'b0, (k % 8 == 7), {a, b, (k < 8), last},
                  last && (last_bits != 8), last);
        end
    endtask

    // Frame ends early: in ADDR (stop_at 1..3) or in PAD (stop_at 4).
    task automatic send_bad(input logic [3:0] a, input int stop_at, input int pad);
        for (int i = 0; i < stop_at; i++) cycle(a[i], 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 1'b0);
        if (stop_at >= 4)
            for (int i = 0; i < pad; i++) cycle(1'($urandom), 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 1'b0);
        cycle(1'($urandom), 1'b1, 1'($urandom), 1'b0, 14'd0, 1'b1, 1'b1);
    endtask

    task automatic check_reset_state();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_head", 32'({out_addr, out_data, out_sop, out_eop}), 32'd0);
        check("rst_err", 32'(err_frame), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy_n), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; din = 1'b0; frame_n = 1'b1; valid_n = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_state();
        reset_n = 1'b1;
        idle(2);

        // Single byte A5 to addr 3 with 5 pad cycles, held then drained.
        ready_mode = 0;
        pkt[0] = 8'hA5;
        send_packet(4'h3, 1, 5, 1'b0, 8);
        idle(2);
        ready_mode = 1;
        idle(2);

        // Two bytes to addr F, no pad, valid_n gaps inside bytes.
        ready_mode = 0;
        pkt[0] = 8'h12; pkt[1] = 8'h34;
        send_packet(4'hF, 2, 0, 1'b1, 8);
        ready_mode = 1;
        idle(3);

        // Partial final byte and early frame ends in ADDR and PAD.
        pkt[0] = 8'h5A;
        send_packet(4'h9, 1, 1, 1'b0, 5);
        idle(1);
        send_bad(4'h6, 4, 2);
        send_bad(4'h6, 2, 0);
        send_bad(4'h1, 4, 0);
        idle(1);

        // Six one-byte packets with no consumer: four kept, then overflow.
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            pkt[0] = 8'(8'h40 + i);
            send_packet(4'(i), 1, i % 2, 1'b0, 8);
        end
        idle(2);

        // Reset in the middle of a payload byte.
        pkt[0] = 8'hC3;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 14'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'($urandom), 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        frame_n = 1'b1; valid_n = 1'b1;
        #1 check_reset_state();
        model_q.delete();
        model_ovf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        ready_mode = 1;
        pkt[0] = 8'h3C;
        send_packet(4'h7, 1, 2, 1'b0, 8);
        idle(3);

        // Randomised traffic with a randomly stalling consumer.
        ready_mode = 2;
        for (int p = 0; p < 60; p++) begin
            int r = int'($urandom % 10);
            if (r == 0) begin
                send_bad(4'($urandom), 1 + int'($urandom % 4), int'($urandom % 3));
            end else begin
                int n = 1 + int'($urandom % 3);
                for (int j = 0; j < n; j++) pkt[j] = 8'($urandom);
                send_packet(4'($urandom), n, int'($urandom % 4), 1'($urandom),
                            (r == 1) ? 1 + int'($urandom % 7) : 8);
            end
            idle(int'($urandom % 3));
        end
        ready_mode = 1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
